// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen_if
// Brief    : Pixel-side bundle of the VGA timing generator: fetch requests
//            toward the framebuffer, returned colour, and the aligned VGA pins.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
    parameter int CNT_W   = 11,
    parameter int COLOR_W = 4
);
    logic [3*COLOR_W-1:0] vga_data;
    logic                 force_blank;
    logic [CNT_W-1:0]     h_addr;
    logic [CNT_W-1:0]     v_addr;
    logic                 rd_en;
    logic                 frame_start;
    logic                 line_start;
    logic [7:0]           frame_cnt;
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [COLOR_W-1:0]   vga_r;
    logic [COLOR_W-1:0]   vga_g;
    logic [COLOR_W-1:0]   vga_b;

    modport master (
        input  vga_data, force_blank,
        output h_addr, v_addr, rd_en, frame_start, line_start, frame_cnt,
        output hsync, vsync, de, vga_r, vga_g, vga_b
    );

    modport slave (
        output vga_data, force_blank,
        input  h_addr, v_addr, rd_en, frame_start, line_start, frame_cnt,
        input  hsync, vsync, de, vga_r, vga_g, vga_b
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised VGA timing generator with fetch-latency-compensated
//            sync, data-enable and colour outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int RD_LAT   = 1,
    parameter int CNT_W    = 11,
    parameter int COLOR_W  = 4
) (
    input  wire logic         pclk,
    input  wire logic         reset,
    vga_timing_gen_if.master  bus
);
    localparam logic [CNT_W-1:0] c_H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_BEG    = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_H_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] c_V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_VS_BEG    = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] c_V_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic             c_HS_ON     = 1'(HS_POL);
    localparam logic             c_VS_ON     = 1'(VS_POL);

    // Bit positions of the flags carried down the alignment pipeline
    localparam int c_B_HS  = 3;
    localparam int c_B_VS  = 2;
    localparam int c_B_ACT = 1;
    localparam int c_B_FB  = 0;

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [7:0]       r_frame_cnt;
    logic             w_active;
    logic             w_hs0;
    logic             w_vs0;
    logic [3:0]       w_stage0;
    logic [3:0]       w_dly;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == c_V_LAST) begin
                r_v_cnt     <= '0;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
                r_v_cnt <= r_v_cnt + c_CNT_ONE;
            end
        end else begin
            r_h_cnt <= r_h_cnt + c_CNT_ONE;
        end
    end

    assign w_active = (r_h_cnt < c_H_ACT_END) && (r_v_cnt < c_V_ACT_END);
    assign w_hs0    = (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
    assign w_vs0    = (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);
    assign w_stage0 = {w_hs0, w_vs0, w_active, bus.force_blank};

    assign bus.rd_en       = w_active;
    assign bus.h_addr      = w_active ? r_h_cnt : '0;
    assign bus.v_addr      = w_active ? r_v_cnt : '0;
    // Counters already sit at (0,0) while reset is held, so the pulses are gated
    assign bus.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0) && !reset;
    assign bus.line_start  = (r_h_cnt == '0) && !reset;
    assign bus.frame_cnt   = r_frame_cnt;

    generate
        if (RD_LAT == 0) begin : g_no_delay
            assign w_dly = w_stage0;
        end else begin : g_delay
            logic [3:0] r_sr [RD_LAT];

            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        r_sr[i] <= '0;
                    end
                end else begin
                    r_sr[0] <= w_stage0;
                    for (int i = 1; i < RD_LAT; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign w_dly = r_sr[RD_LAT-1];
        end
    endgenerate

    // vga_data arrives RD_LAT cycles after its request, in step with w_dly
    always_ff @(posedge pclk) begin
        if (reset) begin
            bus.hsync <= ~c_HS_ON;
            bus.vsync <= ~c_VS_ON;
            bus.de    <= 1'b0;
            bus.vga_r <= '0;
            bus.vga_g <= '0;
            bus.vga_b <= '0;
        end else begin
            bus.hsync <= w_dly[c_B_HS] ? c_HS_ON : ~c_HS_ON;
            bus.vsync <= w_dly[c_B_VS] ? c_VS_ON : ~c_VS_ON;
            bus.de    <= w_dly[c_B_ACT];
            if (w_dly[c_B_ACT] && !w_dly[c_B_FB]) begin
                {bus.vga_r, bus.vga_g, bus.vga_b} <= bus.vga_data;
            end else begin
                bus.vga_r <= '0;
                bus.vga_g <= '0;
                bus.vga_b <= '0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Bench for vga_timing_gen: a latency-2 active-low instance and a
//            latency-0 active-high-hsync instance against a frame-position model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
    localparam int H_ACT = 8, H_FP = 2, H_SY = 3, H_BP = 3;
    localparam int V_ACT = 4, V_FP = 1, V_SY = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;

    localparam int F_FS = 0, F_LS = 1, F_RD = 2, F_HA = 3, F_DE = 4, F_R = 5;
    localparam int F_G = 6, F_B = 7, F_HS = 8, F_VS = 9, F_FC = 10;

    typedef struct packed {
        logic        fs, ls, rd;
        logic [10:0] ha, va;
        logic [7:0]  fc;
        logic        hs, vs, de;
        logic [3:0]  r, g, b;
    } obs_t;

    typedef struct {
        int cyc;
        int dut;
        int fld;
        int val;
    } vec_t;

    logic pclk = 1'b0;
    logic reset = 1'b1;
    logic force_blank = 1'b0;
    logic [11:0] q1, q2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_hit = 0;
    int   t = 0;
    bit   fb_hist [0:65535];
    obs_t obs_a, obs_b, exp_a, exp_b;
    vec_t vecs [$];

    always #5 pclk = ~pclk;

    vga_timing_gen_if #(.CNT_W(11), .COLOR_W(4)) bus_a ();
    vga_timing_gen_if #(.CNT_W(11), .COLOR_W(4)) bus_b ();

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .RD_LAT(2), .CNT_W(11), .COLOR_W(4)
    ) dut_a (.pclk(pclk), .reset(reset), .bus(bus_a.master));

    vga_timing_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HS_POL(1), .VS_POL(0), .RD_LAT(0), .CNT_W(11), .COLOR_W(4)
    ) dut_b (.pclk(pclk), .reset(reset), .bus(bus_b.master));

    function automatic logic [11:0] pat(input logic [10:0] h, input logic [10:0] v);
        return {h[3:0], v[3:0], 4'hA};
    endfunction

    // Framebuffer stand-ins: two-cycle read for A, zero-latency read for B
    always @(posedge pclk) begin
        q1 <= pat(bus_a.h_addr, bus_a.v_addr);
        q2 <= q1;
    end
    assign bus_a.vga_data    = q2;
    assign bus_b.vga_data    = pat(bus_b.h_addr, bus_b.v_addr);
    assign bus_a.force_blank = force_blank;
    assign bus_b.force_blank = force_blank;

    // Expected view at position t (cycles since the counters were last cleared)
    function automatic obs_t model(input int tt, input int lat, input bit hpol,
                                   input bit vpol, input bit rst_now);
        obs_t o;
        int h, v, s, sh, sv;
        bit act, pix;
        h = tt % H_TOT;
        v = (tt / H_TOT) % V_TOT;
        o.rd = (h < H_ACT) && (v < V_ACT);
        o.ha = o.rd ? 11'(h) : 11'd0;
        o.va = o.rd ? 11'(v) : 11'd0;
        o.fs = ((tt % F_TOT) == 0) && !rst_now;
        o.ls = (h == 0) && !rst_now;
        o.fc = 8'((tt / F_TOT) % 256);
        if (tt >= lat + 1) begin
            s   = tt - lat - 1;
            sh  = s % H_TOT;
            sv  = (s / H_TOT) % V_TOT;
            act = (sh < H_ACT) && (sv < V_ACT);
            pix = act && !fb_hist[s];
            o.hs = (sh >= H_ACT + H_FP && sh < H_ACT + H_FP + H_SY) ? hpol : !hpol;
            o.vs = (sv >= V_ACT + V_FP && sv < V_ACT + V_FP + V_SY) ? vpol : !vpol;
            o.de = act;
            o.r  = pix ? 4'(sh) : 4'd0;
            o.g  = pix ? 4'(sv) : 4'd0;
            o.b  = pix ? 4'hA : 4'd0;
        end else begin
            o.hs = !hpol;
            o.vs = !vpol;
            o.de = 1'b0;
            o.r  = 4'd0;
            o.g  = 4'd0;
            o.b  = 4'd0;
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("fs=%0b ls=%0b rd=%0b ha=%0d va=%0d fc=%0d hs=%0b vs=%0b de=%0b rgb=%h%h%h",
                         o.fs, o.ls, o.rd, o.ha, o.va, o.fc, o.hs, o.vs, o.de, o.r, o.g, o.b);
    endfunction

    function automatic int field_of(input obs_t o, input int f);
        case (f)
            F_FS: return int'(o.fs);
            F_LS: return int'(o.ls);
            F_RD: return int'(o.rd);
            F_HA: return int'(o.ha);
            F_DE: return int'(o.de);
            F_R:  return int'(o.r);
            F_G:  return int'(o.g);
            F_B:  return int'(o.b);
            F_HS: return int'(o.hs);
            F_VS: return int'(o.vs);
            default: return int'(o.fc);
        endcase
    endfunction

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o = '{bus_a.frame_start, bus_a.line_start, bus_a.rd_en, bus_a.h_addr, bus_a.v_addr,
                  bus_a.frame_cnt, bus_a.hsync, bus_a.vsync, bus_a.de,
                  bus_a.vga_r, bus_a.vga_g, bus_a.vga_b};
        end else begin
            o = '{bus_b.frame_start, bus_b.line_start, bus_b.rd_en, bus_b.h_addr, bus_b.v_addr,
                  bus_b.frame_cnt, bus_b.hsync, bus_b.vsync, bus_b.de,
                  bus_b.vga_r, bus_b.vga_g, bus_b.vga_b};
        end
        return o;
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0d got %0d want %0d", name, t, act, req);
        end
    endtask

    task automatic check_obs(input string name, input obs_t act, input obs_t req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0d got {%s} want {%s}", name, t, fmt(act), fmt(req));
        end
    endtask

    function automatic void add(input int c, input int d, input int f, input int v);
        vec_t e;
        e.cyc = c; e.dut = d; e.fld = f; e.val = v;
        vecs.push_back(e);
    endfunction

    // One pixel clock: inputs held for the cycle, outputs sampled mid-cycle
    task automatic run_cycle(input bit rst_v, input bit fb_v, input bit dir);
        reset       = rst_v;
        force_blank = fb_v;
        @(negedge pclk);
        fb_hist[t] = fb_v;
        obs_a = sample(0);
        obs_b = sample(1);
        exp_a = model(t, 2, 1'b0, 1'b0, rst_v);
        exp_b = model(t, 0, 1'b1, 1'b0, rst_v);
        check_obs("model_A", obs_a, exp_a);
        check_obs("model_B", obs_b, exp_b);
        if (dir) begin
            foreach (vecs[i]) begin
                if (vecs[i].cyc == t) begin
                    n_hit++;
                    check_val($sformatf("vec%0d_dut%0d_f%0d", i, vecs[i].dut, vecs[i].fld),
                              field_of(vecs[i].dut == 0 ? obs_a : obs_b, vecs[i].fld),
                              vecs[i].val);
                end
            end
        end
        @(posedge pclk);
        t = rst_v ? 0 : t + 1;
        #1;
    endtask

    initial begin
        add(0, 0, F_FS, 1);   add(0, 0, F_LS, 1);   add(0, 0, F_RD, 1);   add(0, 0, F_HA, 0);
        add(3, 0, F_DE, 1);   add(3, 0, F_B, 0);    add(6, 0, F_DE, 1);   add(6, 0, F_R, 0);
        add(7, 0, F_R, 4);    add(7, 0, F_G, 0);    add(7, 0, F_B, 10);
        add(10, 0, F_DE, 1);  add(10, 0, F_R, 7);
        add(7, 0, F_RD, 1);   add(8, 0, F_RD, 0);   add(15, 0, F_RD, 0);
        add(12, 0, F_HS, 1);  add(13, 0, F_HS, 0);  add(15, 0, F_HS, 0);  add(16, 0, F_HS, 1);
        add(16, 0, F_LS, 1);  add(17, 0, F_LS, 0);  add(32, 0, F_LS, 1);
        add(82, 0, F_VS, 1);  add(83, 0, F_VS, 0);  add(114, 0, F_VS, 0); add(115, 0, F_VS, 1);
        add(127, 0, F_FC, 0); add(128, 0, F_FC, 1); add(128, 0, F_FS, 1);
        add(0, 1, F_RD, 1);   add(0, 1, F_DE, 0);   add(1, 1, F_DE, 1);
        add(10, 1, F_HS, 0);  add(11, 1, F_HS, 1);  add(13, 1, F_HS, 1);  add(14, 1, F_HS, 0);

        reset = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        t = 0;
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);

        // Directed first frame: blank the first four requested pixels
        for (int c = 0; c < 200; c++) begin
            run_cycle(1'b0, c < 4, 1'b1);
        end
        check_val("vector_hits", n_hit, vecs.size());

        // Single-cycle reset mid-line, then one landing on a line start
        run_cycle(1'b1, 1'b0, 1'b0);
        while (t < 50) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("rst_hsync", int'(obs_a.hs), 1);
        check_val("rst_vsync", int'(obs_a.vs), 1);
        check_val("rst_de", int'(obs_a.de), 0);
        check_val("rst_rgb", int'({obs_a.r, obs_a.g, obs_a.b}), 0);
        check_val("rst_frame_start", int'(obs_a.fs), 1);
        check_val("rst_h_addr", int'(obs_a.ha), 0);
        while (t < 64) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check_val("rst_no_line_start", int'(obs_a.ls), 0);

        // 256 frames with random blanking: frame counter wraps back to 0
        while (t < 256 * F_TOT - 1) run_cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("frame_cnt_255", int'(obs_a.fc), 255);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("frame_cnt_wrap", int'(obs_a.fc), 0);
        check_val("frame_start_wrap", int'(obs_a.fs), 1);

        // Random blanking with sporadic resets
        for (int c = 0; c < 4000; c++) begin
            run_cycle(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed-mode VGA driver. Generates horizontal/vertical timing for any resolution from four-segment parameters and issues pixel fetch addresses ahead of display. Compensates a configurable framebuffer read latency so that sync, data-enable and colour leave the block aligned. Sits between the framebuffer/sprite compositor (address out, colour in) and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
RD_LAT, 1, cycles from h_addr/v_addr/rd_en to valid vga_data; legal range 0..4
CNT_W, 11, width of counters and address outputs
COLOR_W, 4, bits per colour channel

Ports:
pclk  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
vga_data  in  3*COLOR_W  pixel colour {R,G,B}; valid RD_LAT cycles after the matching request
force_blank  in  1  forces black on pixels requested while high
h_addr  out  CNT_W  column of the pixel being requested; 0 outside the active region
v_addr  out  CNT_W  row of the pixel being requested; 0 outside the active region
rd_en  out  1  request-side active-region flag
frame_start  out  1  one-cycle pulse when the counters are at (0,0)
line_start  out  1  one-cycle pulse when h_cnt = 0
frame_cnt  out  8  frame counter; increments on frame wrap, wraps 255->0
hsync  out  1  registered, latency-aligned horizontal sync
vsync  out  1  registered, latency-aligned vertical sync
de  out  1  registered, latency-aligned data enable
vga_r  out  COLOR_W  registered red
vga_g  out  COLOR_W  registered green
vga_b  out  COLOR_W  registered blue

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h_cnt runs 0..H_TOTAL-1; v_cnt advances only when h_cnt = H_TOTAL-1 and wraps V_TOTAL-1 -> 0. frame_cnt increments on that same wrap cycle.
- Segment order per axis: active, front porch, sync, back porch. Active when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. hsync stage-0 is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt, for all cycles of those lines.
- Request side (stage 0) is combinational from the counters:
  - rd_en = active; h_addr = h_cnt and v_addr = v_cnt when active, else 0.
  - frame_start = (h_cnt=0 & v_cnt=0 & !reset); line_start = (h_cnt=0 & !reset).
- Alignment pipeline: stage-0 hsync, vsync, active and force_blank pass through a RD_LAT-deep shift register, then through the output register.
  - Outputs therefore reflect counter state n at cycle n+RD_LAT+1.
  - vga_r/g/b are registered from vga_data when the delayed active flag is set and the delayed force_blank is clear; otherwise they are 0.
  - de is the registered delayed active flag; it stays high during force_blank.
  - Sync outputs drive the HS_POL/VS_POL level when asserted and the inverse level otherwise.
- Reset, held while reset is high:
  - h_cnt, v_cnt and frame_cnt are 0; the shift-register contents are inactive.
  - Registered outputs: hsync = ~HS_POL, vsync = ~VS_POL, de = 0, rgb = 0.
  - frame_start and line_start are 0.
  - Reset asserted mid-frame takes effect on the next edge; no partial pulse is emitted.
  - On the first cycle after release the counters are at (0,0), so frame_start and line_start are 1.
- RD_LAT = 0: the shift register is bypassed and outputs lag the counters by exactly 1 cycle.
- No other inputs affect the counters; force_blank never alters timing.

Test Plan:
- Params H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), RD_LAT=2, HS_POL=VS_POL=0. Bench drives vga_data = {h_addr[3:0], v_addr[3:0], 4'hA} delayed 2 cycles. Reset released at cycle 0 -> cycle 0: frame_start=1, line_start=1, rd_en=1, h_addr=0. Cycle 3: de=1, vga_r=0, vga_g=0, vga_b=A. Cycle 10: de=1, vga_r=7.
- Same setup -> rd_en high at cycles 0..7 and low at 8..15; hsync low exactly at cycles 13..15 of line 0; line_start pulses at cycles 16, 32, ...
- Same setup -> vsync low exactly at cycles 83..114. frame_start pulses again at cycle 128, when frame_cnt becomes 1. Run 256 frames -> frame_cnt wraps to 0.
- Set force_blank=1 during cycles 0..3 -> vga_r/g/b = 0 at cycles 3..6 with de=1; normal colour from cycle 7.
- Assert reset for 1 cycle at cycle 50, mid-line -> next edge: counters 0, hsync=vsync=1, de=0, rgb=0. After release: frame_start at the first released cycle, then the timing of test 1 repeats.
- RD_LAT=0 with HS_POL=1 -> de rises 1 cycle after rd_en; hsync high exactly at cycles 11..13; idle level 0.
